// File: rtl/wolfram_ca_engine.sv
// Runtime-programmable elementary cellular automaton: WIDTH cells, radius RADIUS,
// rule truth table indexed by the neighbourhood, iterated for a requested step count.
//
// state | meaning
// IDLE  | waiting; load / rule_we / start accepted
// RUN   | one generation per clock, busy high
// DONE  | one-cycle done pulse; load / rule_we / start accepted
module wolfram_ca_engine #(
  parameter int WIDTH                     = 16,
  parameter int RADIUS                    = 1,
  parameter int RULE_W                    = 2**(2*RADIUS+1),
  parameter logic [RULE_W-1:0] DEFAULT_RULE = '0,
  parameter int CNT_W                     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rule_we,
  input  logic [RULE_W-1:0] rule_in,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_state,
  input  logic              wrap,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_steps,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  state,
  output logic [CNT_W-1:0]  steps_done
);

  localparam int N = 2*RADIUS+1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t                       fsm;
  logic [RULE_W-1:0]          rule_q;
  logic                       wrap_q;
  logic [CNT_W-1:0]           target;
  logic [RADIUS-1:0]          hi_pad;
  logic [RADIUS-1:0]          lo_pad;
  logic [WIDTH+2*RADIUS-1:0]  ext;
  logic [WIDTH-1:0]           nxt;
  logic [CNT_W-1:0]           steps_inc;

  // Pad the cell vector with RADIUS cells on each side so that cell i's
  // neighbourhood is the contiguous slice ext[i +: N], MSB = highest cell.
  assign hi_pad = wrap_q ? state[RADIUS-1:0] : '0;
  assign lo_pad = wrap_q ? state[WIDTH-1:WIDTH-RADIUS] : '0;
  assign ext    = {hi_pad, state, lo_pad};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign nxt[i] = rule_q[ext[i +: N]];
  end

  assign steps_inc = steps_done + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      state      <= '0;
      rule_q     <= DEFAULT_RULE;
      wrap_q     <= 1'b0;
      target     <= '0;
      steps_done <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
          if (rule_we) rule_q <= rule_in;
          if (load)    state  <= load_state;
          if (start) begin
            steps_done <= '0;
            target     <= num_steps;
            wrap_q     <= wrap;
            if (num_steps == '0) begin
              fsm  <= DONE;
              done <= 1'b1;
            end else begin
              fsm  <= RUN;
              busy <= 1'b1;
            end
          end
        end
        RUN: begin
          state      <= nxt;
          steps_done <= steps_inc;
          if (steps_inc == target) begin
            fsm  <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
